uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter C_DATA_W, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter C_FIFO_DEPTH, default 16, TX FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter C_DIV_W, default 16, width of bit-period divider.
REQ-004 SHALL have port Clk  input  1  single clock for all logic.
REQ-005 SHALL have port Rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port iTx_Clk_Div  input  C_DIV_W  Clk cycles per bit.
REQ-007 SHALL have port iTx_Val  input  1  write strobe for iTx_Data.
REQ-008 SHALL have port iTx_Data  input  C_DATA_W  byte to queue.
REQ-009 SHALL have port iTx_Check_odd  input  1  odd parity enable.
REQ-010 SHALL have port iTx_Check_even  input  1  even parity enable.
REQ-011 SHALL have port iTx_Stop2  input  1  two stop bits when 1, else one.
REQ-012 SHALL have port oTx_Bit  output  1  serial line, idle high.
REQ-013 SHALL have port oTx_Rdy  output  1  FIFO not full (write will be accepted).
REQ-014 SHALL have port oTx_done  output  1  one-cycle pulse at end of each frame.
REQ-015 SHALL have port oTx_Busy  output  1  frame in progress.
REQ-016 SHALL have port oTx_Level  output  log2(C_FIFO_DEPTH)+1  FIFO occupancy.
REQ-017 SHALL have port oTx_Ovf  output  1  one-cycle pulse when a write is dropped.

Function
REQ-018 SHALL accept a write on a rising Clk edge where iTx_Val=1 and oTx_Rdy=1; oTx_Rdy is registered = (level < C_FIFO_DEPTH).
REQ-019 SHALL drop a write with iTx_Val=1 and oTx_Rdy=0, FIFO contents unchanged, pulsing oTx_Ovf the following cycle.
REQ-020 SHALL support simultaneous push and pop in one cycle, level unchanged; pointers wrap modulo C_FIFO_DEPTH.
REQ-021 SHALL implement FSM IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE or START.
REQ-022 SHALL, in IDLE with level>0, pop the head entry, latch data, parity mode, stop count and divider, and enter START on the same edge; oTx_Bit falls one cycle after the accepting edge when FIFO was empty.
REQ-023 SHALL hold each bit for max(iTx_Clk_Div,1) cycles using the latched divider; divider changes take effect only at the next frame start.
REQ-024 SHALL send start bit 0, then C_DATA_W data bits LSB first, then parity if enabled, then 1 or 2 stop bits of 1.
REQ-025 SHALL compute parity so ones(data)+parity is even (iTx_Check_even) or odd (iTx_Check_odd); both set or both clear SHALL mean no parity.
REQ-026 SHALL pulse oTx_done in the last cycle of the final stop bit.
REQ-027 SHALL, if level>0 at end of final stop bit, pop and enter START directly (no idle gap between frames).
REQ-028 SHALL assert oTx_Busy in all states except IDLE.

Reset
REQ-029 SHALL on Rst=0 immediately force oTx_Bit=1, oTx_Rdy=0, oTx_done=0, oTx_Busy=0, oTx_Level=0, oTx_Ovf=0, FSM=IDLE, FIFO pointers=0.
REQ-030 SHALL raise oTx_Rdy=1 on the first Clk edge after Rst deasserts.
REQ-031 SHALL, on reset mid-frame, abandon the frame and discard all queued data; no oTx_done is produced for it.

Verification
REQ-032 SHALL cover: div=4, even parity, one stop, write 8'hA5 -> line 0,1,0,1,0,0,1,0,1,parity 0,1; 44 cycles, oTx_done in cycle 44 after start.
REQ-033 SHALL cover: div=4, odd parity, iTx_Stop2=1, write 8'h01 -> parity bit 0, 12-bit frame, 48 cycles.
REQ-034 SHALL cover: div=8, 18 consecutive writes from empty -> 17 accepted, oTx_Rdy=0 after 17th, 18th dropped with one oTx_Ovf pulse, oTx_Level=16.
REQ-035 SHALL cover: div=4, both parity enables set, writes 8'h00 then 8'hFF back-to-back -> 10-bit frames, oTx_done pulses exactly 40 cycles apart, no idle gap.
REQ-036 SHALL cover: Rst=0 during data bit 3 with 4 entries queued -> oTx_Bit=1 asynchronously, oTx_Level=0, no further oTx_done.
REQ-037 SHALL cover: C_DATA_W=7 instance, no parity, write 7'h55 -> 9-bit frame, data 1,0,1,0,1,0,1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter behind a FIFO: a frame starts the cycle after a write into an empty queue.
// Writes are accepted while oTx_Rdy is high; a write with oTx_Rdy low is dropped and flagged on oTx_Ovf.
module uart_tx_fifo #(
  parameter int C_DATA_W     = 8,
  parameter int C_FIFO_DEPTH = 16,
  parameter int C_DIV_W      = 16
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [C_DIV_W-1:0]              iTx_Clk_Div,
  input  logic                            iTx_Val,
  input  logic [C_DATA_W-1:0]             iTx_Data,
  input  logic                            iTx_Check_odd,
  input  logic                            iTx_Check_even,
  input  logic                            iTx_Stop2,
  output logic                            oTx_Bit,
  output logic                            oTx_Rdy,
  output logic                            oTx_done,
  output logic                            oTx_Busy,
  output logic [$clog2(C_FIFO_DEPTH):0]   oTx_Level,
  output logic                            oTx_Ovf
);
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(C_DATA_W);
  localparam logic [LW-1:0]      DEPTH_L  = LW'(C_FIFO_DEPTH);
  localparam logic [LW-1:0]      L_ONE    = LW'(1);
  localparam logic [AW-1:0]      A_ONE    = AW'(1);
  localparam logic [BW-1:0]      B_ONE    = BW'(1);
  localparam logic [BW-1:0]      LAST_BIT = BW'(C_DATA_W - 1);
  localparam logic [C_DIV_W-1:0] D_ONE    = C_DIV_W'(1);
  localparam logic [C_DIV_W-1:0] D_TWO    = C_DIV_W'(2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t              state;
  logic [C_DATA_W-1:0] mem [C_FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level_nx;
  logic                push, pop;
  logic [C_DATA_W-1:0] head, sh;
  logic [C_DIV_W-1:0]  div_q, div_l, cnt;
  logic [BW-1:0]       bit_cnt;
  logic                par_en_q, par_q, stop2_q, stop_cnt;
  logic                bit_end, final_stop, single;

  assign push       = iTx_Val & oTx_Rdy;
  assign head       = mem[rd_ptr];
  assign div_l      = (div_q == '0) ? D_ONE : div_q;
  assign bit_end    = (cnt == div_l - D_ONE);
  assign single     = (div_l == D_ONE);
  assign final_stop = (stop_cnt == stop2_q);

  always_comb begin
    pop = 1'b0;
    if (oTx_Level != '0) begin
      if (state == S_IDLE) pop = 1'b1;
      else if (state == S_STOP && bit_end && final_stop) pop = 1'b1;
    end
    level_nx = oTx_Level;
    if (push && !pop) level_nx = oTx_Level + L_ONE;
    else if (!push && pop) level_nx = oTx_Level - L_ONE;
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= iTx_Data;
  end

  // Ready is computed from the post-edge level so a full queue blocks the very next write.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      oTx_Level <= '0;
      oTx_Rdy   <= 1'b0;
      oTx_Ovf   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + A_ONE;
      if (pop)  rd_ptr <= rd_ptr + A_ONE;
      oTx_Level <= level_nx;
      oTx_Rdy   <= (level_nx < DEPTH_L);
      oTx_Ovf   <= iTx_Val & ~oTx_Rdy;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      sh       <= '0;
      bit_cnt  <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      stop_cnt <= 1'b0;
      div_q    <= '0;
      oTx_Bit  <= 1'b1;
      oTx_Busy <= 1'b0;
      oTx_done <= 1'b0;
    end else begin
      oTx_done <= 1'b0;
      if (pop) begin
        state    <= S_START;
        cnt      <= '0;
        sh       <= head;
        par_en_q <= iTx_Check_odd ^ iTx_Check_even;
        par_q    <= iTx_Check_odd ? ~^head : ^head;
        stop2_q  <= iTx_Stop2;
        div_q    <= iTx_Clk_Div;
        oTx_Bit  <= 1'b0;
        oTx_Busy <= 1'b1;
      end else if (state != S_IDLE) begin
        if (!bit_end) begin
          cnt      <= cnt + D_ONE;
          // Raise done one edge early so it covers the last cycle of the final stop bit.
          oTx_done <= (state == S_STOP) && final_stop && (cnt == div_l - D_TWO);
        end else begin
          cnt <= '0;
          case (state)
            S_START: begin
              state   <= S_DATA;
              bit_cnt <= '0;
              oTx_Bit <= sh[0];
            end
            S_DATA: begin
              if (bit_cnt == LAST_BIT) begin
                if (par_en_q) begin
                  state   <= S_PARITY;
                  oTx_Bit <= par_q;
                end else begin
                  state    <= S_STOP;
                  stop_cnt <= 1'b0;
                  oTx_Bit  <= 1'b1;
                  oTx_done <= single && !stop2_q;
                end
              end else begin
                bit_cnt <= bit_cnt + B_ONE;
                sh      <= sh >> 1;
                oTx_Bit <= sh[1];
              end
            end
            S_PARITY: begin
              state    <= S_STOP;
              stop_cnt <= 1'b0;
              oTx_Bit  <= 1'b1;
              oTx_done <= single && !stop2_q;
            end
            S_STOP: begin
              if (!final_stop) begin
                stop_cnt <= 1'b1;
                oTx_done <= single;
              end else begin
                state    <= S_IDLE;
                oTx_Busy <= 1'b0;
                oTx_Bit  <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: table of single frames, then burst, back-to-back, 7-bit and mid-frame reset sequences.
module tb_uart_tx_fifo;
  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [15:0] div = '0;
  logic        val = 1'b0;
  logic [7:0]  data = '0;
  logic        odd = 1'b0, even = 1'b0, stop2 = 1'b0;
  logic        tx_bit, tx_rdy, tx_done, tx_busy, tx_ovf;
  logic [4:0]  tx_level;

  logic        val7 = 1'b0;
  logic [6:0]  data7 = '0;
  logic        tx7_bit, tx7_rdy, tx7_done, tx7_busy, tx7_ovf;
  logic [4:0]  tx7_level;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  uart_tx_fifo #(.C_DATA_W(8), .C_FIFO_DEPTH(16), .C_DIV_W(16)) u_dut (
    .Clk(Clk), .Rst(Rst), .iTx_Clk_Div(div), .iTx_Val(val), .iTx_Data(data),
    .iTx_Check_odd(odd), .iTx_Check_even(even), .iTx_Stop2(stop2),
    .oTx_Bit(tx_bit), .oTx_Rdy(tx_rdy), .oTx_done(tx_done), .oTx_Busy(tx_busy),
    .oTx_Level(tx_level), .oTx_Ovf(tx_ovf)
  );

  uart_tx_fifo #(.C_DATA_W(7), .C_FIFO_DEPTH(16), .C_DIV_W(16)) u_dut7 (
    .Clk(Clk), .Rst(Rst), .iTx_Clk_Div(div), .iTx_Val(val7), .iTx_Data(data7),
    .iTx_Check_odd(1'b0), .iTx_Check_even(1'b0), .iTx_Stop2(1'b0),
    .oTx_Bit(tx7_bit), .oTx_Rdy(tx7_rdy), .oTx_done(tx7_done), .oTx_Busy(tx7_busy),
    .oTx_Level(tx7_level), .oTx_Ovf(tx7_ovf)
  );

  typedef struct {
    logic [15:0] bits;  // line value per bit, bit 0 = start bit
    int          n;
    int          per;
  } frame_t;

  typedef struct {
    logic [7:0]  d;
    logic [15:0] dv;
    logic        o, e, s2;
    logic [15:0] exp_bits;
    int          exp_n;
    int          exp_per;
  } vec_t;

  frame_t sb[$];
  vec_t   tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic frame_t make_frame(input logic [7:0] d, input logic o, input logic e,
                                        input logic s2, input int per);
    frame_t f;
    int ones;
    f.bits = '0;
    f.n = 1;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f.bits[f.n] = d[i];
      if (d[i]) ones++;
      f.n++;
    end
    if (o != e) begin
      f.bits[f.n] = e ? ((ones % 2) == 1) : ((ones % 2) == 0);
      f.n++;
    end
    f.bits[f.n] = 1'b1;
    f.n++;
    if (s2) begin
      f.bits[f.n] = 1'b1;
      f.n++;
    end
    f.per = per;
    return f;
  endfunction

  // Waits for a start bit, then checks every cycle of the frame against the scoreboard head.
  task automatic expect_frame(input bit sel, input string tag, output int waited, output int done_cyc);
    frame_t      e;
    logic [15:0] got;
    logic        ln;
    int          hold_bad, busy_bad, nd, done_at;
    waited = 0;
    done_cyc = -1;
    do begin
      @(negedge Clk);
      waited++;
      ln = sel ? tx7_bit : tx_bit;
    end while (ln !== 1'b0 && waited < 4000);
    if (ln !== 1'b0) begin
      check({tag, "_start_timeout"}, 32'(ln), 0);
      return;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    got = '0;
    hold_bad = 0; busy_bad = 0; nd = 0; done_at = -1;
    for (int c = 0; c < e.n * e.per; c++) begin
      if (c > 0) @(negedge Clk);
      ln = sel ? tx7_bit : tx_bit;
      if (c % e.per == 0) got[c / e.per] = ln;
      else if (ln !== got[c / e.per]) hold_bad++;
      if ((sel ? tx7_busy : tx_busy) !== 1'b1) busy_bad++;
      if ((sel ? tx7_done : tx_done) === 1'b1) begin
        nd++;
        done_at = c + 1;
        done_cyc = cyc;
      end
    end
    check({tag, "_frame"}, 32'(got), 32'(e.bits));
    check({tag, "_hold"}, hold_bad, 0);
    check({tag, "_busy"}, busy_bad, 0);
    check({tag, "_done_cnt"}, nd, 1);
    check({tag, "_done_pos"}, done_at, e.n * e.per);
  endtask

  int w0, w1, dc0, dc1, ndone, nlow;
  logic [7:0] rd;

  initial begin
    tbl[0] = '{8'hA5, 16'd4, 1'b0, 1'b1, 1'b0, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 4};
    tbl[1] = '{8'h01, 16'd4, 1'b1, 1'b0, 1'b1, 16'({1'b1, 1'b1, 1'b0, 8'h01, 1'b0}), 12, 4};
    tbl[2] = '{8'h3C, 16'd1, 1'b0, 1'b1, 1'b1, 16'({1'b1, 1'b1, 1'b0, 8'h3C, 1'b0}), 12, 1};
    tbl[3] = '{8'h80, 16'd0, 1'b1, 1'b0, 1'b0, 16'({1'b1, 1'b0, 8'h80, 1'b0}), 11, 1};
    tbl[4] = '{8'h96, 16'd3, 1'b0, 1'b0, 1'b0, 16'({1'b1, 8'h96, 1'b0}), 10, 3};
    tbl[5] = '{8'h07, 16'd2, 1'b0, 1'b1, 1'b0, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 2};
    tbl[6] = '{8'hC3, 16'd5, 1'b1, 1'b1, 1'b1, 16'({1'b1, 1'b1, 8'hC3, 1'b0}), 11, 5};

    #12;
    check("rst_bit", 32'(tx_bit), 1);
    check("rst_rdy", 32'(tx_rdy), 0);
    check("rst_done", 32'(tx_done), 0);
    check("rst_busy", 32'(tx_busy), 0);
    check("rst_level", 32'(tx_level), 0);
    check("rst_ovf", 32'(tx_ovf), 0);
    @(negedge Clk);
    Rst = 1'b1;
    #1 check("rdy_before_edge", 32'(tx_rdy), 0);
    @(negedge Clk);
    check("rdy_after_rst", 32'(tx_rdy), 1);

    for (int i = 0; i < 7; i++) begin
      sb.push_back('{tbl[i].exp_bits, tbl[i].exp_n, tbl[i].exp_per});
      fork
        begin
          val = 1'b1; data = tbl[i].d; div = tbl[i].dv;
          odd = tbl[i].o; even = tbl[i].e; stop2 = tbl[i].s2;
          @(negedge Clk);
          val = 1'b0;
          @(negedge Clk);
          // Settings changed after the frame has started must not affect it.
          div = tbl[i].dv + 16'd5; odd = ~odd; even = ~even; stop2 = ~stop2;
        end
        expect_frame(1'b0, $sformatf("vec%0d", i), w0, dc0);
      join
      @(negedge Clk);
      check($sformatf("vec%0d_idle_bit", i), 32'(tx_bit), 1);
      check($sformatf("vec%0d_idle_busy", i), 32'(tx_busy), 0);
    end

    div = 16'd4; odd = 1'b1; even = 1'b1; stop2 = 1'b0;
    sb.push_back(make_frame(8'h00, 1'b1, 1'b1, 1'b0, 4));
    sb.push_back(make_frame(8'hFF, 1'b1, 1'b1, 1'b0, 4));
    fork
      begin
        val = 1'b1; data = 8'h00;
        @(negedge Clk);
        data = 8'hFF;
        @(negedge Clk);
        val = 1'b0;
      end
      begin
        expect_frame(1'b0, "b2b0", w0, dc0);
        expect_frame(1'b0, "b2b1", w1, dc1);
      end
    join
    check("b2b_gap", w1, 1);
    check("b2b_spacing", dc1 - dc0, 40);

    div = 16'd8; odd = 1'b0; even = 1'b0; stop2 = 1'b0;
    @(negedge Clk);
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          rd = 8'($urandom);
          data = rd;
          val = 1'b1;
          check($sformatf("burst_rdy%0d", i), 32'(tx_rdy), (i < 17) ? 1 : 0);
          if (i < 17) sb.push_back(make_frame(rd, 1'b0, 1'b0, 1'b0, 8));
          @(negedge Clk);
        end
        val = 1'b0;
        check("burst_ovf", 32'(tx_ovf), 1);
        check("burst_level", 32'(tx_level), 16);
        check("burst_rdy_full", 32'(tx_rdy), 0);
        @(negedge Clk);
        check("burst_ovf_single", 32'(tx_ovf), 0);
      end
      begin
        for (int k = 0; k < 17; k++) expect_frame(1'b0, $sformatf("burst%0d", k), w0, dc0);
      end
    join

    div = 16'd4;
    sb.push_back('{16'({1'b1, 7'h55, 1'b0}), 9, 4});
    @(negedge Clk);
    fork
      begin
        val7 = 1'b1; data7 = 7'h55;
        @(negedge Clk);
        val7 = 1'b0;
      end
      expect_frame(1'b1, "w7", w0, dc0);
    join

    // Mid-frame reset: five writes of 0x00, reset lands in data bit 3 of the first frame.
    @(negedge Clk);
    data = 8'h00;
    for (int i = 0; i < 5; i++) begin
      val = 1'b1;
      @(negedge Clk);
    end
    val = 1'b0;
    repeat (14) @(negedge Clk);
    check("mid_level", 32'(tx_level), 4);
    check("mid_bit_low", 32'(tx_bit), 0);
    #2 Rst = 1'b0;
    #1;
    check("arst_bit", 32'(tx_bit), 1);
    check("arst_level", 32'(tx_level), 0);
    check("arst_busy", 32'(tx_busy), 0);
    check("arst_rdy", 32'(tx_rdy), 0);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    ndone = 0; nlow = 0;
    repeat (200) begin
      @(negedge Clk);
      if (tx_done !== 1'b0) ndone++;
      if (tx_bit !== 1'b1) nlow++;
    end
    check("post_rst_done", ndone, 0);
    check("post_rst_line", nlow, 0);
    check("post_rst_level", 32'(tx_level), 0);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
